// File: rtl/sfifo_pkg.sv
// Shared definitions for the SFIFO write scheduler: FSM encoding, period floor, header layout.
package sfifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HDR  = 3'd3,
    ST_XFER = 3'd4
  } state_t;

  localparam int         MIN_PERIOD    = 4;
  localparam logic [3:0] HDR_MAGIC     = 4'hA;
  localparam int         HDR_MAGIC_LSB = 12;
  localparam int         HDR_ID_LSB    = 8;
  localparam int         HDR_SEQ_LSB   = 0;

endpackage

// File: rtl/sfifo_bp_gen.sv
// Base-period counter: registered 2-clock tick on bp_cnt 0/1, combinational frame-start pulse.
// Period changes are picked up when the counter sits at 0; disabled means counter parked at 0.
module sfifo_bp_gen
  import sfifo_pkg::*;
#(
  parameter int BP_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [BP_W-1:0] i_period,
  output logic            o_tick,
  output logic            o_fs
);

  logic [BP_W-1:0] r_cnt;
  logic [BP_W-1:0] r_per;
  logic [BP_W-1:0] w_per_in;
  logic            r_tick;

  assign w_per_in = (i_period < BP_W'(MIN_PERIOD)) ? BP_W'(MIN_PERIOD) : i_period;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_per  <= BP_W'(MIN_PERIOD);
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt <= BP_W'(1));
      // the period in force for a frame is latched as the frame begins
      if (r_cnt == '0) begin
        r_per <= w_per_in;
        r_cnt <= BP_W'(1);
      end else if (r_cnt == r_per - BP_W'(1)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + BP_W'(1);
      end
    end
  end

  assign o_tick = r_tick;
  assign o_fs   = i_en && (r_cnt == '0);

endmodule

// File: rtl/sfifo_wr_sched.sv
// SFIFO producer scheduler: one packet per requester per base period, round-robin, zero-latency word forwarding.
// sfifo_full_i stalls writes but never drops a grant; define SFIFO_HDR_EN to prefix each packet with a header word.
module sfifo_wr_sched
  import sfifo_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SFIFO_DW = 16,
  parameter int BP_W     = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     bp_en_i,
  input  logic [BP_W-1:0]          bp_period_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          last_i,
  input  logic [NREQ*SFIFO_DW-1:0] dat_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          ack_o,
  output logic                     sfifo_wr_o,
  output logic [SFIFO_DW-1:0]      sfifo_do,
  input  logic                     sfifo_full_i,
  output logic                     sfifo_bp_tick_o,
  output logic [NREQ-1:0]          ovr_o,
  input  logic                     ovr_clr_i
);

`ifdef SFIFO_HDR_EN
  localparam state_t ST_FIRST = ST_HDR;
`else
  localparam state_t ST_FIRST = ST_XFER;
`endif

  state_t                r_state, w_state_nxt;
  logic [NREQ-1:0]       r_served, r_gnt, r_ovr;
  logic [NREQ-1:0]       w_served_eff, w_elig, w_rot, w_pick_oh, w_ack;
  logic [3:0]            r_rr, w_pick, w_rr_nxt;
  logic [4:0]            w_off, w_sum;
  logic                  w_fs, w_found, w_arb_now, w_last, w_hdr_wr;
  logic [SFIFO_DW-1:0]   w_dat, w_hdr;

  sfifo_bp_gen #(.BP_W(BP_W)) u_bp_gen (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_en     (bp_en_i),
    .i_period (bp_period_i),
    .o_tick   (sfifo_bp_tick_o),
    .o_fs     (w_fs)
  );

  // at frame start only the in-flight packet keeps its served bit
  assign w_served_eff = w_fs ? r_gnt : r_served;
  assign w_elig       = req_i & ~w_served_eff;
  assign w_arb_now    = (r_state == ST_ARB) || ((r_state == ST_WAIT) && w_fs);
  assign w_rot        = NREQ'({w_elig, w_elig} >> r_rr);

  always_comb begin
    w_found   = 1'b0;
    w_off     = '0;
    w_pick_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = 5'(k);
      end
    end
    w_sum  = {1'b0, r_rr} + w_off;
    w_pick = (w_sum >= 5'(NREQ)) ? 4'(w_sum - 5'(NREQ)) : 4'(w_sum);
    for (int i = 0; i < NREQ; i++) begin
      w_pick_oh[i] = w_found && (w_pick == 4'(i));
    end
  end

  assign w_rr_nxt = (w_pick == 4'(NREQ - 1)) ? 4'd0 : w_pick + 4'd1;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_fs) w_state_nxt = ST_ARB;
      ST_ARB, ST_WAIT: begin
        if (w_arb_now)    w_state_nxt = w_found ? ST_FIRST : ST_WAIT;
        else if (|w_elig) w_state_nxt = ST_ARB;
      end
      ST_HDR:  if (w_hdr_wr) w_state_nxt = ST_XFER;
      ST_XFER: if (w_last) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // reset gates the strobes so an abandoned packet issues nothing more
  always_comb begin
    w_ack    = '0;
    w_hdr_wr = 1'b0;
    if (wb_rst_ni && !sfifo_full_i) begin
      if (r_state == ST_XFER) w_ack = r_gnt & req_i;
      if (r_state == ST_HDR)  w_hdr_wr = 1'b1;
    end
  end

  always_comb begin
    w_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_dat = w_dat | dat_i[i*SFIFO_DW +: SFIFO_DW];
    end
  end

`ifdef SFIFO_HDR_EN
  logic [3:0] r_gid;
  logic [7:0] r_seq;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_gid <= '0;
      r_seq <= '0;
    end else begin
      if (w_fs) r_seq <= r_seq + 8'd1;
      if (w_arb_now && w_found) r_gid <= w_pick;
    end
  end

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_MAGIC_LSB +: 4] = HDR_MAGIC;
    w_hdr[HDR_ID_LSB +: 4]    = r_gid;
    w_hdr[HDR_SEQ_LSB +: 8]   = r_seq;
  end
`else
  assign w_hdr = '0;
`endif

  assign w_last     = |(w_ack & last_i);
  assign ack_o      = w_ack;
  assign gnt_o      = r_gnt;
  assign ovr_o      = r_ovr;
  assign sfifo_wr_o = (|w_ack) || w_hdr_wr;
  assign sfifo_do   = w_hdr_wr ? w_hdr : ((|w_ack) ? w_dat : '0);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_served <= '0;
      r_gnt    <= '0;
      r_ovr    <= '0;
      r_rr     <= '0;
    end else begin
      // per-bit: a new miss at frame start beats a simultaneous clear
      r_ovr    <= (ovr_clr_i ? '0 : r_ovr) | (w_fs ? (req_i & ~r_served) : '0);
      r_served <= w_served_eff | (w_arb_now ? w_pick_oh : '0);
      if (w_arb_now && w_found) begin
        r_gnt <= w_pick_oh;
        r_rr  <= w_rr_nxt;
      end else if (w_last) begin
        r_gnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sfifo_wr_sched.sv
// Directed bench for sfifo_wr_sched: per-cycle log of outputs compared against hand-derived timelines.
`timescale 1ns/1ps
module tb_sfifo_wr_sched;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int BP_W = 32;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_ni, bp_en_i, sfifo_full_i, ovr_clr_i;
  logic [BP_W-1:0]      bp_period_i;
  logic [NREQ-1:0]      req_i, last_i, gnt_o, ack_o, ovr_o;
  logic [NREQ*DW-1:0]   dat_i;
  logic                 sfifo_wr_o, sfifo_bp_tick_o;
  logic [DW-1:0]        sfifo_do;

  always #5 wb_clk_i = ~wb_clk_i;

  sfifo_wr_sched #(.NREQ(NREQ), .SFIFO_DW(DW), .BP_W(BP_W)) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_ni       (wb_rst_ni),
    .bp_en_i         (bp_en_i),
    .bp_period_i     (bp_period_i),
    .req_i           (req_i),
    .last_i          (last_i),
    .dat_i           (dat_i),
    .gnt_o           (gnt_o),
    .ack_o           (ack_o),
    .sfifo_wr_o      (sfifo_wr_o),
    .sfifo_do        (sfifo_do),
    .sfifo_full_i    (sfifo_full_i),
    .sfifo_bp_tick_o (sfifo_bp_tick_o),
    .ovr_o           (ovr_o),
    .ovr_clr_i       (ovr_clr_i)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc;
  int rem[NREQ], wcnt[NREQ], npk[NREQ], plen[NREQ], st[NREQ];
  int f_lo, f_hi, clr_cyc, rst_cyc;

  logic [NREQ-1:0] lg_gnt[0:63];
  logic [NREQ-1:0] lg_ovr[0:63];
  logic            lg_wr[0:63];
  logic            lg_tick[0:63];
  logic [DW-1:0]   lg_do[0:63];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    wb_rst_ni    = (cyc < rst_cyc);
    sfifo_full_i = (cyc >= f_lo) && (cyc <= f_hi);
    ovr_clr_i    = (cyc == clr_cyc);
    for (int i = 0; i < NREQ; i++) begin
      req_i[i]  = (cyc >= st[i]) && (rem[i] > 0);
      last_i[i] = (rem[i] == 1);
      dat_i[i*DW +: DW] = {4'(i), 12'(wcnt[i])};
    end
  endtask

  task automatic step();
    @(negedge wb_clk_i);
    if (cyc >= 0 && cyc < 64) begin
      lg_gnt[cyc]  = gnt_o;
      lg_ovr[cyc]  = ovr_o;
      lg_wr[cyc]   = sfifo_wr_o;
      lg_tick[cyc] = sfifo_bp_tick_o;
      lg_do[cyc]   = sfifo_do;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack_o[i]) begin
        wcnt[i]++;
        if (rem[i] == 1 && npk[i] > 0) begin
          npk[i]--;
          rem[i] = plen[i];
        end else begin
          rem[i]--;
        end
      end
    end
    @(posedge wb_clk_i);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_to(input int last);
    while (cyc <= last) step();
  endtask

  task automatic begin_test(input int per);
    wb_rst_ni = 1'b0;
    bp_period_i = BP_W'(per);
    bp_en_i = 1'b1;
    req_i = '0; last_i = '0; dat_i = '0;
    sfifo_full_i = 1'b0; ovr_clr_i = 1'b0;
    f_lo = 1000; f_hi = -1; clr_cyc = -5; rst_cyc = 1000;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; wcnt[i] = 0; npk[i] = 0; plen[i] = 0; st[i] = 0;
    end
    for (int c = 0; c < 64; c++) begin
      lg_gnt[c] = '0; lg_ovr[c] = '0; lg_wr[c] = 1'b0; lg_tick[c] = 1'b0; lg_do[c] = '0;
    end
  endtask

  task automatic pkt(input int i, input int len, input int extra, input int start);
    plen[i] = len; rem[i] = len; npk[i] = extra; st[i] = start;
  endtask

  task automatic go();
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("reset_state", {2'b00, gnt_o, ack_o, sfifo_wr_o, sfifo_do, sfifo_bp_tick_o, ovr_o}, 32'd0);
    @(posedge wb_clk_i);
    #1;
    cyc = -1;
    drive();
  endtask

  logic            ew[0:27];
  logic [DW-1:0]   ed[0:27];

  initial begin
    // tick cadence, period 10, no requests
    begin_test(10);
    go();
    run_to(24);
    for (int c = 0; c < 25; c++)
      chk($sformatf("t1_tick_wr_c%0d", c), {30'd0, lg_tick[c], lg_wr[c]},
          {30'd0, ((c % 10) <= 1), 1'b0});

    // period below the floor runs as 4; disabling parks the tick low
    begin_test(2);
    go();
    run_to(9);
    for (int c = 0; c < 10; c++)
      chk($sformatf("t1b_tick_c%0d", c), {31'd0, lg_tick[c]}, {31'd0, ((c % 4) <= 1)});
    bp_en_i = 1'b0;
    run_to(13);
    for (int c = 11; c < 14; c++)
      chk($sformatf("t1b_dis_tick_c%0d", c), {31'd0, lg_tick[c]}, 32'd0);

    // two requesters, two 3-word packets each, period 20
    begin_test(20);
    pkt(0, 3, 1, 0);
    pkt(2, 3, 1, 0);
    go();
    run_to(27);
    for (int c = 0; c < 28; c++) begin ew[c] = 1'b0; ed[c] = '0; end
    for (int k = 0; k < 3; k++) begin
      ew[1+k]  = 1'b1; ed[1+k]  = 16'h0000 + 16'(k);
      ew[5+k]  = 1'b1; ed[5+k]  = 16'h2000 + 16'(k);
      ew[20+k] = 1'b1; ed[20+k] = 16'h0003 + 16'(k);
      ew[24+k] = 1'b1; ed[24+k] = 16'h2003 + 16'(k);
    end
    for (int c = 0; c < 28; c++) begin
      chk($sformatf("t2_wr_c%0d", c), {31'd0, lg_wr[c]}, {31'd0, ew[c]});
      if (ew[c]) chk($sformatf("t2_do_c%0d", c), {16'd0, lg_do[c]}, {16'd0, ed[c]});
    end
    chk("t2_gnt_c1", {28'd0, lg_gnt[1]}, 32'b0001);
    chk("t2_gnt_c5", {28'd0, lg_gnt[5]}, 32'b0100);
    chk("t2_gnt_wait_c12", {28'd0, lg_gnt[12]}, 32'd0);
    chk("t2_gnt_c20", {28'd0, lg_gnt[20]}, 32'b0001);
    chk("t2_ovr_c27", {28'd0, lg_ovr[27]}, 32'd0);

    // full stall mid-packet, then reset mid-packet
    begin_test(40);
    pkt(0, 8, 0, 0);
    f_lo = 3; f_hi = 7; rst_cyc = 10;
    go();
    run_to(11);
    chk("t3_do_c1", {16'd0, lg_do[1]}, 32'h0000);
    chk("t3_do_c2", {16'd0, lg_do[2]}, 32'h0001);
    chk("t3_do_c8", {16'd0, lg_do[8]}, 32'h0002);
    chk("t3_do_c9", {16'd0, lg_do[9]}, 32'h0003);
    for (int c = 3; c < 8; c++)
      chk($sformatf("t3_stall_c%0d", c), {27'd0, lg_gnt[c], lg_wr[c]}, {27'd0, 4'b0001, 1'b0});
    chk("t3_rst_wr_c10", {31'd0, lg_wr[10]}, 32'd0);
    chk("t3_after_rst_c11", {6'd0, lg_gnt[11], lg_wr[11], lg_do[11], lg_tick[11], lg_ovr[11]}, 32'd0);
    chk("t3_words", wcnt[0], 4);

    // 20-word packet across frames of 8; req3 misses frame 0
    begin_test(8);
    pkt(1, 20, 0, 0);
    pkt(3, 2, 0, 2);
    clr_cyc = 26;
    go();
    run_to(27);
    chk("t4_gnt_c8", {28'd0, lg_gnt[8]}, 32'b0010);
    chk("t4_gnt_c16", {28'd0, lg_gnt[16]}, 32'b0010);
    chk("t4_do_c20", {16'd0, lg_do[20]}, 32'h1013);
    chk("t4_gnt_c21", {27'd0, lg_gnt[21], lg_wr[21]}, 32'd0);
    chk("t4_gnt_c22", {28'd0, lg_gnt[22]}, 32'b1000);
    chk("t4_do_c23", {16'd0, lg_do[23]}, 32'h3001);
    chk("t4_ovr_c7", {28'd0, lg_ovr[7]}, 32'd0);
    chk("t4_ovr_c8", {28'd0, lg_ovr[8]}, 32'b1000);
    chk("t4_ovr_c25", {28'd0, lg_ovr[25]}, 32'b1000);
    chk("t4_ovr_clr_c27", {28'd0, lg_ovr[27]}, 32'd0);
    chk("t4_words", wcnt[1], 20);

    // all four requesting continuously, 2-word packets, period 10
    begin_test(10);
    for (int i = 0; i < NREQ; i++) pkt(i, 2, 100, 0);
    go();
    run_to(33);
    for (int k = 0; k < 11; k++)
      chk($sformatf("t5_gnt_c%0d", 1 + 3*k), {28'd0, lg_gnt[1+3*k]}, 32'(1 << (k % 4)));
    chk("t5_bubble_c9", {31'd0, lg_wr[9]}, 32'd0);
    chk("t5_ovr_c10", {28'd0, lg_ovr[10]}, 32'b1000);
    chk("t5_ovr_c33", {28'd0, lg_ovr[33]}, 32'b1000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
